// File: rtl/hls_mem_arb_pkg.sv
// Shared constants for the two-port HLS memory arbiter: FSM encodings,
// requester ids and the supported RAM read-latency range.
package hls_mem_arb_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_ARB   = 3'b001;
  localparam arb_state_t ST_LOCK0 = 3'b010;
  localparam arb_state_t ST_LOCK1 = 3'b100;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Out-of-range latencies are pinned to the nearest supported value.
  function automatic int clamp_rd_lat(input int lat);
    int res;
    if (lat < RD_LAT_MIN) begin
      res = RD_LAT_MIN;
    end else if (lat > RD_LAT_MAX) begin
      res = RD_LAT_MAX;
    end else begin
      res = lat;
    end
    return res;
  endfunction

endpackage

// File: rtl/hls_mem_port_arbiter_if.sv
// Bundle of both requester ports, the RAM port and busy. The master side
// is the kernels plus RAM macro; the slave side is the arbiter.
interface hls_mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          r0_ce;
  logic          r0_we;
  logic [AW-1:0] r0_address;
  logic [DW-1:0] r0_d;
  logic          r0_lock;
  logic          r0_gnt;
  logic [DW-1:0] r0_q;
  logic          r0_qvalid;

  logic          r1_ce;
  logic          r1_we;
  logic [AW-1:0] r1_address;
  logic [DW-1:0] r1_d;
  logic          r1_lock;
  logic          r1_gnt;
  logic [DW-1:0] r1_q;
  logic          r1_qvalid;

  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  logic          busy;

  modport master (
    output r0_ce, r0_we, r0_address, r0_d, r0_lock,
    input  r0_gnt, r0_q, r0_qvalid,
    output r1_ce, r1_we, r1_address, r1_d, r1_lock,
    input  r1_gnt, r1_q, r1_qvalid,
    input  mem_ce, mem_we, mem_address, mem_d,
    output mem_q,
    input  busy
  );

  modport slave (
    input  r0_ce, r0_we, r0_address, r0_d, r0_lock,
    output r0_gnt, r0_q, r0_qvalid,
    input  r1_ce, r1_we, r1_address, r1_d, r1_lock,
    output r1_gnt, r1_q, r1_qvalid,
    output mem_ce, mem_we, mem_address, mem_d,
    input  mem_q,
    output busy
  );
endinterface

// File: rtl/hls_mem_rd_tag_pipe.sv
// Shift pipe carrying {valid,id} of each issued read so the owner tag lines
// up with mem_q after RD_LAT cycles.
module hls_mem_rd_tag_pipe
  import hls_mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic in_valid,
  input  logic in_id,
  output logic out_valid,
  output logic out_id,
  output logic any_valid
);

  localparam int DEPTH = clamp_rd_lat(RD_LAT);

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] id_r;

  // Tag shift register; reset discards every in-flight read.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid_r <= '0;
      id_r    <= '0;
    end else begin
      valid_r[0] <= in_valid;
      id_r[0]    <= in_id;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        id_r[i]    <= id_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_id    = id_r[DEPTH-1];
  assign any_valid = |valid_r;

endmodule

// File: rtl/hls_mem_port_arbiter.sv
// Round-robin arbiter sharing one ap_memory RAM between two HLS kernel ports,
// with optional ownership lock and per-requester read-data return.
module hls_mem_port_arbiter
  import hls_mem_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  hls_mem_port_arbiter_if.slave  bus
);

  arb_state_t    state_r;
  arb_state_t    state_nxt_s;
  logic          rr_r;
  logic          rr_nxt_s;
  logic          gnt0_s;
  logic          gnt1_s;

  logic          mem_ce_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_address_r;
  logic [DW-1:0] mem_d_r;
  logic          mem_rd_id_r;
  logic          rd_issue_s;

  logic          tag_valid_s;
  logic          tag_id_s;
  logic          tag_any_s;
  logic          r0_qvalid_s;
  logic          r1_qvalid_s;
  logic [DW-1:0] r0_q_r;
  logic [DW-1:0] r1_q_r;

  // Grant decision and next FSM/round-robin state; rr_r names the contention winner.
  always_comb begin
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    state_nxt_s = state_r;
    rr_nxt_s    = rr_r;
    case (state_r)
      ST_ARB: begin
        if (bus.r0_ce && bus.r1_ce) begin
          if (rr_r == REQ0) begin
            gnt0_s   = 1'b1;
            rr_nxt_s = REQ1;
          end else begin
            gnt1_s   = 1'b1;
            rr_nxt_s = REQ0;
          end
        end else if (bus.r0_ce) begin
          gnt0_s   = 1'b1;
          rr_nxt_s = REQ1;
        end else if (bus.r1_ce) begin
          gnt1_s   = 1'b1;
          rr_nxt_s = REQ0;
        end else begin
          rr_nxt_s = rr_r;
        end
        if (gnt0_s && bus.r0_lock) begin
          state_nxt_s = ST_LOCK0;
        end else if (gnt1_s && bus.r1_lock) begin
          state_nxt_s = ST_LOCK1;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      // Lock is released whenever the owner drops lock, with or without an access.
      ST_LOCK0: begin
        gnt0_s = bus.r0_ce;
        if (bus.r0_lock) begin
          state_nxt_s = ST_LOCK0;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_LOCK1: begin
        gnt1_s = bus.r1_ce;
        if (bus.r1_lock) begin
          state_nxt_s = ST_LOCK1;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      default: begin
        state_nxt_s = ST_ARB;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r <= ST_ARB;
      rr_r    <= REQ0;
    end else begin
      state_r <= state_nxt_s;
      rr_r    <= rr_nxt_s;
    end
  end

  // RAM command registers; address/data hold when idle, ce/we pulse per access.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mem_ce_r      <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_address_r <= '0;
      mem_d_r       <= '0;
      mem_rd_id_r   <= REQ0;
    end else if (gnt1_s) begin
      mem_ce_r      <= 1'b1;
      mem_we_r      <= bus.r1_we;
      mem_address_r <= bus.r1_address;
      mem_d_r       <= bus.r1_d;
      mem_rd_id_r   <= REQ1;
    end else if (gnt0_s) begin
      mem_ce_r      <= 1'b1;
      mem_we_r      <= bus.r0_we;
      mem_address_r <= bus.r0_address;
      mem_d_r       <= bus.r0_d;
      mem_rd_id_r   <= REQ0;
    end else begin
      mem_ce_r      <= 1'b0;
      mem_we_r      <= 1'b0;
    end
  end

  assign rd_issue_s = mem_ce_r & ~mem_we_r;

  hls_mem_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (rd_issue_s),
    .in_id     (mem_rd_id_r),
    .out_valid (tag_valid_s),
    .out_id    (tag_id_s),
    .any_valid (tag_any_s)
  );

  assign r0_qvalid_s = tag_valid_s & (tag_id_s == REQ0);
  assign r1_qvalid_s = tag_valid_s & (tag_id_s == REQ1);

  // Last returned word per requester, shown while its qvalid is low.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r0_q_r <= '0;
      r1_q_r <= '0;
    end else begin
      if (r0_qvalid_s) begin
        r0_q_r <= bus.mem_q;
      end else begin
        r0_q_r <= r0_q_r;
      end
      if (r1_qvalid_s) begin
        r1_q_r <= bus.mem_q;
      end else begin
        r1_q_r <= r1_q_r;
      end
    end
  end

  assign bus.r0_gnt      = gnt0_s;
  assign bus.r1_gnt      = gnt1_s;
  assign bus.r0_qvalid   = r0_qvalid_s;
  assign bus.r1_qvalid   = r1_qvalid_s;
  assign bus.r0_q        = r0_qvalid_s ? bus.mem_q : r0_q_r;
  assign bus.r1_q        = r1_qvalid_s ? bus.mem_q : r1_q_r;
  assign bus.mem_ce      = mem_ce_r;
  assign bus.mem_we      = mem_we_r;
  assign bus.mem_address = mem_address_r;
  assign bus.mem_d       = mem_d_r;
  assign bus.busy        = (state_r != ST_ARB) | rd_issue_s | tag_any_s;

endmodule

// File: tb/tb_hls_mem_port_arbiter.sv
// Directed bench: RD_LAT=1 arbiter (dut_a) and RD_LAT=3 arbiter (dut_b),
// each with a small behavioural RAM.
module tb_hls_mem_port_arbiter;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 ap_clk = ~ap_clk;

  hls_mem_port_arbiter_if #(.AW(32), .DW(32)) a_if ();
  hls_mem_port_arbiter_if #(.AW(32), .DW(32)) b_if ();

  hls_mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(a_if));
  hls_mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(b_if));

  function automatic logic [31:0] preset(input logic [5:0] a);
    logic [31:0] v;
    case (a)
      6'd5:    v = 32'hDEAD_BEEF;
      6'd7:    v = 32'h7777_0007;
      6'd10:   v = 32'hA0A0_0010;
      6'd20:   v = 32'hB1B1_0020;
      default: v = 32'h5A00_0000 | {26'd0, a};
    endcase
    return v;
  endfunction

  // RAM models: contents preset while reset is low.
  logic [31:0] ram_a [0:63];
  logic [31:0] ram_b [0:63];
  logic [31:0] qa;
  logic [31:0] qb [0:2];

  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < 64; i++) begin
        ram_a[i] <= preset(i[5:0]);
        ram_b[i] <= preset(i[5:0]);
      end
      qa <= 32'd0;
      for (int i = 0; i < 3; i++) qb[i] <= 32'd0;
    end else begin
      if (a_if.mem_ce && a_if.mem_we) ram_a[a_if.mem_address[5:0]] <= a_if.mem_d;
      qa <= (a_if.mem_ce && !a_if.mem_we) ? ram_a[a_if.mem_address[5:0]] : 32'd0;
      if (b_if.mem_ce && b_if.mem_we) ram_b[b_if.mem_address[5:0]] <= b_if.mem_d;
      qb[0] <= (b_if.mem_ce && !b_if.mem_we) ? ram_b[b_if.mem_address[5:0]] : 32'd0;
      qb[1] <= qb[0];
      qb[2] <= qb[1];
    end
  end

  assign a_if.mem_q = qa;
  assign b_if.mem_q = qb[2];

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge ap_clk);
  endtask

  task automatic idle_all();
    a_if.r0_ce = 1'b0; a_if.r0_we = 1'b0; a_if.r0_address = 32'd0; a_if.r0_d = 32'd0; a_if.r0_lock = 1'b0;
    a_if.r1_ce = 1'b0; a_if.r1_we = 1'b0; a_if.r1_address = 32'd0; a_if.r1_d = 32'd0; a_if.r1_lock = 1'b0;
    b_if.r0_ce = 1'b0; b_if.r0_we = 1'b0; b_if.r0_address = 32'd0; b_if.r0_d = 32'd0; b_if.r0_lock = 1'b0;
    b_if.r1_ce = 1'b0; b_if.r1_we = 1'b0; b_if.r1_address = 32'd0; b_if.r1_d = 32'd0; b_if.r1_lock = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    smp();
    checks++; if ({a_if.mem_ce, a_if.mem_we, a_if.busy} !== 3'b000) begin
      failures++; $display("FAIL reset_ctl_a got=%b exp=000", {a_if.mem_ce, a_if.mem_we, a_if.busy}); end
    checks++; if ({a_if.mem_address, a_if.mem_d} !== 64'd0) begin
      failures++; $display("FAIL reset_addr_d_a got=%h exp=0", {a_if.mem_address, a_if.mem_d}); end
    checks++; if ({a_if.r0_q, a_if.r1_q, a_if.r0_qvalid, a_if.r1_qvalid} !== 66'd0) begin
      failures++; $display("FAIL reset_q_a got=%h exp=0", {a_if.r0_q, a_if.r1_q, a_if.r0_qvalid, a_if.r1_qvalid}); end
    checks++; if ({b_if.mem_ce, b_if.busy, b_if.r0_qvalid, b_if.r1_qvalid} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctl_b got=%b exp=0000", {b_if.mem_ce, b_if.busy, b_if.r0_qvalid, b_if.r1_qvalid}); end
    #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    step(); a_if.r0_ce = 1'b1; a_if.r0_address = 32'd5; smp();
    checks++; if ({a_if.r0_gnt, a_if.r1_gnt} !== 2'b10) begin
      failures++; $display("FAIL single_gnt got=%b exp=10", {a_if.r0_gnt, a_if.r1_gnt}); end
    step(); a_if.r0_ce = 1'b0; smp();
    checks++; if ({a_if.mem_ce, a_if.mem_we, a_if.r0_qvalid} !== 3'b100 || a_if.mem_address !== 32'd5) begin
      failures++; $display("FAIL single_mem got=%b addr=%0d exp=100 addr=5", {a_if.mem_ce, a_if.mem_we, a_if.r0_qvalid}, a_if.mem_address); end
    step(); smp();
    checks++; if ({a_if.r0_qvalid, a_if.r1_qvalid} !== 2'b10 || a_if.r0_q !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL single_ret got=%b q=%h exp=10 q=deadbeef", {a_if.r0_qvalid, a_if.r1_qvalid}, a_if.r0_q); end
    step(); smp();
    checks++; if ({a_if.r0_qvalid, a_if.busy, a_if.mem_ce} !== 3'b000 || a_if.r0_q !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL single_hold got=%b q=%h exp=000 q=deadbeef", {a_if.r0_qvalid, a_if.busy, a_if.mem_ce}, a_if.r0_q); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    logic [1:0] exp_v;
    do_reset();
    a_if.r0_address = 32'd10;
    a_if.r1_address = 32'd20;
    for (int k = 0; k < 6; k++) begin
      step();
      a_if.r0_ce = (k < 4);
      a_if.r1_ce = (k < 4);
      smp();
      exp_g = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
      exp_v = (k < 2) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
      checks++; if ({a_if.r0_gnt, a_if.r1_gnt} !== exp_g) begin
        failures++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, {a_if.r0_gnt, a_if.r1_gnt}, exp_g); end
      checks++; if ({a_if.r0_qvalid, a_if.r1_qvalid} !== exp_v) begin
        failures++; $display("FAIL rr_qvalid k=%0d got=%b exp=%b", k, {a_if.r0_qvalid, a_if.r1_qvalid}, exp_v); end
      if (exp_v == 2'b10) begin
        checks++; if (a_if.r0_q !== 32'hA0A0_0010) begin
          failures++; $display("FAIL rr_q0 k=%0d got=%h exp=a0a00010", k, a_if.r0_q); end
      end else if (exp_v == 2'b01) begin
        checks++; if (a_if.r1_q !== 32'hB1B1_0020) begin
          failures++; $display("FAIL rr_q1 k=%0d got=%h exp=b1b10020", k, a_if.r1_q); end
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    step(); a_if.r0_ce = 1'b1; a_if.r0_we = 1'b1; a_if.r0_address = 32'd9; a_if.r0_d = 32'h99; smp();
    checks++; if (a_if.r0_gnt !== 1'b1) begin failures++; $display("FAIL lock_pre got=%b exp=1", a_if.r0_gnt); end
    step(); a_if.r0_we = 1'b0; a_if.r0_address = 32'd7;
    a_if.r1_ce = 1'b1; a_if.r1_we = 1'b1; a_if.r1_address = 32'd3; a_if.r1_d = 32'h1234_5678; a_if.r1_lock = 1'b1; smp();
    checks++; if ({a_if.r0_gnt, a_if.r1_gnt} !== 2'b01) begin
      failures++; $display("FAIL lock_wr_gnt got=%b exp=01", {a_if.r0_gnt, a_if.r1_gnt}); end
    step(); a_if.r1_we = 1'b0; a_if.r1_lock = 1'b0; smp();
    checks++; if ({a_if.r0_gnt, a_if.r1_gnt, a_if.busy} !== 3'b011) begin
      failures++; $display("FAIL lock_rd_gnt got=%b exp=011", {a_if.r0_gnt, a_if.r1_gnt, a_if.busy}); end
    checks++; if (a_if.mem_we !== 1'b1 || a_if.mem_address !== 32'd3 || a_if.mem_d !== 32'h1234_5678) begin
      failures++; $display("FAIL lock_mem_wr got=%b %0d %h exp=1 3 12345678", a_if.mem_we, a_if.mem_address, a_if.mem_d); end
    step(); a_if.r1_ce = 1'b0; smp();
    checks++; if ({a_if.r0_gnt, a_if.r1_gnt, a_if.r0_qvalid, a_if.r1_qvalid} !== 4'b1000) begin
      failures++; $display("FAIL lock_after got=%b exp=1000", {a_if.r0_gnt, a_if.r1_gnt, a_if.r0_qvalid, a_if.r1_qvalid}); end
    step(); a_if.r0_ce = 1'b0; smp();
    checks++; if ({a_if.r0_qvalid, a_if.r1_qvalid} !== 2'b01 || a_if.r1_q !== 32'h1234_5678) begin
      failures++; $display("FAIL lock_r1_ret got=%b q=%h exp=01 q=12345678", {a_if.r0_qvalid, a_if.r1_qvalid}, a_if.r1_q); end
    step(); smp();
    checks++; if ({a_if.r0_qvalid, a_if.r1_qvalid} !== 2'b10 || a_if.r0_q !== 32'h7777_0007) begin
      failures++; $display("FAIL lock_r0_ret got=%b q=%h exp=10 q=77770007", {a_if.r0_qvalid, a_if.r1_qvalid}, a_if.r0_q); end
  endtask

  task automatic test_lock_release();
    do_reset();
    step(); a_if.r0_ce = 1'b1; a_if.r0_address = 32'd5; a_if.r0_lock = 1'b1;
    a_if.r1_ce = 1'b1; a_if.r1_we = 1'b1; a_if.r1_address = 32'd30; a_if.r1_d = 32'h30; smp();
    checks++; if ({a_if.r0_gnt, a_if.r1_gnt} !== 2'b10) begin
      failures++; $display("FAIL rel_gnt0 got=%b exp=10", {a_if.r0_gnt, a_if.r1_gnt}); end
    step(); a_if.r0_ce = 1'b0; a_if.r0_lock = 1'b0; smp();
    checks++; if ({a_if.r0_gnt, a_if.r1_gnt, a_if.busy} !== 3'b001) begin
      failures++; $display("FAIL rel_locked got=%b exp=001", {a_if.r0_gnt, a_if.r1_gnt, a_if.busy}); end
    step(); smp();
    checks++; if ({a_if.r1_gnt, a_if.r0_qvalid, a_if.busy} !== 3'b111 || a_if.r0_q !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL rel_gnt1 got=%b q=%h exp=111 q=deadbeef", {a_if.r1_gnt, a_if.r0_qvalid, a_if.busy}, a_if.r0_q); end
    step(); a_if.r1_ce = 1'b0; smp();
    checks++; if ({a_if.busy, a_if.r0_qvalid, a_if.r1_qvalid} !== 3'b000) begin
      failures++; $display("FAIL rel_idle got=%b exp=000", {a_if.busy, a_if.r0_qvalid, a_if.r1_qvalid}); end
  endtask

  task automatic test_rd_lat3();
    logic [31:0] exp_d;
    logic        exp_v;
    logic        exp_b;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      b_if.r0_ce = (k < 3);
      b_if.r0_address = 32'(k + 1);
      smp();
      exp_v = (k >= 4) && (k <= 6);
      exp_b = (k >= 1) && (k <= 6);
      exp_d = 32'h5A00_0000 + 32'(k - 3);
      checks++; if (b_if.r0_gnt !== (k < 3)) begin
        failures++; $display("FAIL lat3_gnt k=%0d got=%b exp=%b", k, b_if.r0_gnt, (k < 3)); end
      checks++; if ({b_if.r0_qvalid, b_if.r1_qvalid, b_if.busy} !== {exp_v, 1'b0, exp_b}) begin
        failures++; $display("FAIL lat3_vb k=%0d got=%b exp=%b", k, {b_if.r0_qvalid, b_if.r1_qvalid, b_if.busy}, {exp_v, 1'b0, exp_b}); end
      if (exp_v) begin
        checks++; if (b_if.r0_q !== exp_d) begin
          failures++; $display("FAIL lat3_q k=%0d got=%h exp=%h", k, b_if.r0_q, exp_d); end
      end
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    step(); a_if.r0_ce = 1'b1; a_if.r0_address = 32'd5; a_if.r0_lock = 1'b1; smp();
    checks++; if (a_if.r0_gnt !== 1'b1) begin failures++; $display("FAIL mid_gnt got=%b exp=1", a_if.r0_gnt); end
    step(); idle_all(); ap_rst_n = 1'b0; smp();
    checks++; if ({a_if.mem_ce, a_if.busy, a_if.r0_qvalid} !== 3'b000 || a_if.mem_address !== 32'd0) begin
      failures++; $display("FAIL mid_rst got=%b addr=%0d exp=000 addr=0", {a_if.mem_ce, a_if.busy, a_if.r0_qvalid}, a_if.mem_address); end
    step(); ap_rst_n = 1'b1; smp();
    for (int k = 0; k < 3; k++) begin
      step(); smp();
      checks++; if ({a_if.r0_qvalid, a_if.r1_qvalid, a_if.busy} !== 3'b000 || a_if.r0_q !== 32'd0) begin
        failures++; $display("FAIL mid_quiet k=%0d got=%b q=%h exp=000 q=0", k, {a_if.r0_qvalid, a_if.r1_qvalid, a_if.busy}, a_if.r0_q); end
    end
    step(); a_if.r1_ce = 1'b1; a_if.r1_address = 32'd20; smp();
    checks++; if ({a_if.r0_gnt, a_if.r1_gnt} !== 2'b01) begin
      failures++; $display("FAIL mid_resume got=%b exp=01", {a_if.r0_gnt, a_if.r1_gnt}); end
    step(); a_if.r1_ce = 1'b0; smp();
    step(); smp();
    checks++; if ({a_if.r0_qvalid, a_if.r1_qvalid} !== 2'b01 || a_if.r1_q !== 32'hB1B1_0020) begin
      failures++; $display("FAIL mid_ret got=%b q=%h exp=01 q=b1b10020", {a_if.r0_qvalid, a_if.r1_qvalid}, a_if.r1_q); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_lock();
    test_lock_release();
    test_rd_lat3();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
